tgt_axi_regs: RTL and testbench

//  AXI4-lite responder for the PCI target bridge's register-space master port (tgt_m_*); terminates PCI BAR accesses in a local register bank.

---
 rtl/pr6120_regs_pkg.sv | 43 ++++
 rtl/tgt_axi_regs.sv | 193 +++++++++++++++++++
 tb/tb_tgt_axi_regs.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr6120_regs_pkg.sv
// Shared definitions for the PCI target register bank: register offsets,
// AXI response codes, FSM state types and small helpers.
package pr6120_regs_pkg;

  localparam logic [31:0] OFF_ID         = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL       = 32'h0000_0004;
  localparam logic [31:0] OFF_STAT       = 32'h0000_0008;
  localparam logic [31:0] OFF_INT_STATUS = 32'h0000_000C;
  localparam logic [31:0] OFF_INT_MASK   = 32'h0000_0010;
  localparam logic [31:0] OFF_EVT_CNT    = 32'h0000_0014;
  localparam logic [31:0] OFF_SCRATCH    = 32'h0000_0018;

  // Word indices used by the address decoders.
  localparam logic [29:0] IDX_ID         = OFF_ID[31:2];
  localparam logic [29:0] IDX_CTRL       = OFF_CTRL[31:2];
  localparam logic [29:0] IDX_STAT       = OFF_STAT[31:2];
  localparam logic [29:0] IDX_INT_STATUS = OFF_INT_STATUS[31:2];
  localparam logic [29:0] IDX_INT_MASK   = OFF_INT_MASK[31:2];
  localparam logic [29:0] IDX_EVT_CNT    = OFF_EVT_CNT[31:2];
  localparam logic [29:0] IDX_SCRATCH    = OFF_SCRATCH[31:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rd_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/tgt_axi_regs.sv
// AXI4-lite register bank terminating PCI BAR accesses from the target bridge.
// Optional TGT_REGS_DECERR_EN: DECERR for unmapped, SLVERR for RO-register writes.
module tgt_axi_regs
  import pr6120_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = 32'h6120_0001,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           tgt_s_awaddr,
  input  logic                  tgt_s_awvalid,
  output logic                  tgt_s_awready,
  input  logic [31:0]           tgt_s_wdata,
  input  logic [3:0]            tgt_s_wstrb,
  input  logic                  tgt_s_wvalid,
  output logic                  tgt_s_wready,
  output logic [1:0]            tgt_s_bresp,
  output logic                  tgt_s_bvalid,
  input  logic                  tgt_s_bready,
  input  logic [31:0]           tgt_s_araddr,
  input  logic [3:0]            tgt_s_aruser,
  input  logic                  tgt_s_arvalid,
  output logic                  tgt_s_arready,
  output logic [31:0]           tgt_s_rdata,
  output logic [1:0]            tgt_s_rresp,
  output logic                  tgt_s_rvalid,
  input  logic                  tgt_s_rready,
  output logic [31:0]           ctrl_out,
  input  logic [31:0]           stat_in,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  intr_request
);

  wr_state_e wst_q;
  rd_state_e rst_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, intr_q;
  logic [1:0] bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] ctrl_q, ctrl_d, mask_q, mask_d, scratch_q, scratch_d, cnt_q, cnt_d;
  logic [NUM_EVENTS-1:0] status_q, status_d, clr_bits;
  logic [31:0] wmask, wbits, rd_word, rd_data;
  logic [32:0] cnt_sum;
  logic [1:0] wr_resp, rd_resp;
  logic cnt_clr;
  logic [29:0] aw_idx, ar_idx;
  logic unused_addr_bits;

  assign aw_idx = 30'(tgt_s_awaddr[ADDR_BITS-1:2]);
  assign ar_idx = 30'(tgt_s_araddr[ADDR_BITS-1:2]);
  assign unused_addr_bits = ^{tgt_s_awaddr[31:ADDR_BITS], tgt_s_awaddr[1:0],
                              tgt_s_araddr[31:ADDR_BITS], tgt_s_araddr[1:0]};

  // Write commit happens on the edge that ends W_ACK (the AW/W handshake edge).
  always_comb begin
    wmask     = strb_mask(tgt_s_wstrb);
    wbits     = tgt_s_wdata & wmask;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    clr_bits  = '0;
    cnt_clr   = 1'b0;
    wr_resp   = RESP_OKAY;
    if (wst_q == W_ACK) begin
      case (aw_idx)
        IDX_CTRL:       ctrl_d    = (ctrl_q & ~wmask) | wbits;
        IDX_INT_STATUS: clr_bits  = wbits[NUM_EVENTS-1:0];
        IDX_INT_MASK:   mask_d    = (mask_q & ~wmask) | wbits;
        IDX_EVT_CNT:    cnt_clr   = 1'b1;
        IDX_SCRATCH:    scratch_d = (scratch_q & ~wmask) | wbits;
`ifdef TGT_REGS_DECERR_EN
        IDX_ID, IDX_STAT: wr_resp = RESP_SLVERR;
        default:          wr_resp = RESP_DECERR;
`else
        default: ;
`endif
      endcase
    end
    status_d = (status_q & ~clr_bits) | event_in;
    cnt_sum  = {1'b0, cnt_q} + 33'(popcount32(32'(event_in)));
    cnt_d    = cnt_clr ? '0 : (cnt_sum[32] ? '1 : cnt_sum[31:0]);
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      IDX_ID:         rd_word = ID_VALUE;
      IDX_CTRL:       rd_word = ctrl_q;
      IDX_STAT:       rd_word = stat_in;
      IDX_INT_STATUS: rd_word = 32'(status_q);
      IDX_INT_MASK:   rd_word = mask_q;
      IDX_EVT_CNT:    rd_word = cnt_q;
      IDX_SCRATCH:    rd_word = scratch_q;
`ifdef TGT_REGS_DECERR_EN
      default:        rd_resp = RESP_DECERR;
`else
      default:        rd_word = '0;
`endif
    endcase
    rd_data = rd_word & strb_mask(tgt_s_aruser);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q    <= '0;
      mask_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      intr_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      intr_q    <= |(status_q & mask_q[NUM_EVENTS-1:0]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wst_q)
        W_IDLE: if (tgt_s_awvalid && tgt_s_wvalid) begin
          wst_q     <= W_ACK;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
        W_ACK: begin
          wst_q     <= W_RESP;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_resp;
        end
        W_RESP: if (tgt_s_bready) begin
          wst_q    <= W_IDLE;
          bvalid_q <= 1'b0;
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rst_q)
        R_IDLE: if (tgt_s_arvalid) begin
          rst_q     <= R_ACK;
          arready_q <= 1'b1;
        end
        R_ACK: begin
          rst_q     <= R_RESP;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_data;
          rresp_q   <= rd_resp;
        end
        R_RESP: if (tgt_s_rready) begin
          rst_q    <= R_IDLE;
          rvalid_q <= 1'b0;
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  assign tgt_s_awready = awready_q;
  assign tgt_s_wready  = wready_q;
  assign tgt_s_bvalid  = bvalid_q;
  assign tgt_s_bresp   = bresp_q;
  assign tgt_s_arready = arready_q;
  assign tgt_s_rvalid  = rvalid_q;
  assign tgt_s_rdata   = rdata_q;
  assign tgt_s_rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign intr_request  = intr_q;

endmodule

// File: tb/tb_tgt_axi_regs.sv
// Randomized self-checking bench for tgt_axi_regs against a behavioural register model.
module tb_tgt_axi_regs;
  localparam int unsigned NE = 8;
  localparam logic [31:0] ID = 32'h6120_0001;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, stat_in = '0;
  logic [3:0] wstrb = '0, aruser = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [NE-1:0] event_in = '0, ev_next = '0;
  logic awready, wready, bvalid, arready, rvalid, intr_request;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, ctrl_out;

  always #5 CLK = ~CLK;

  tgt_axi_regs #(.ID_VALUE(ID), .ADDR_BITS(8), .NUM_EVENTS(NE)) dut (
    .CLK(CLK), .RST(RST),
    .tgt_s_awaddr(awaddr), .tgt_s_awvalid(awvalid), .tgt_s_awready(awready),
    .tgt_s_wdata(wdata), .tgt_s_wstrb(wstrb), .tgt_s_wvalid(wvalid), .tgt_s_wready(wready),
    .tgt_s_bresp(bresp), .tgt_s_bvalid(bvalid), .tgt_s_bready(bready),
    .tgt_s_araddr(araddr), .tgt_s_aruser(aruser), .tgt_s_arvalid(arvalid), .tgt_s_arready(arready),
    .tgt_s_rdata(rdata), .tgt_s_rresp(rresp), .tgt_s_rvalid(rvalid), .tgt_s_rready(rready),
    .ctrl_out(ctrl_out), .stat_in(stat_in), .event_in(event_in), .intr_request(intr_request)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit ev_rand = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_ctrl = '0, m_mask = '0, m_scratch = '0, m_cnt = '0;
  logic [NE-1:0] m_status = '0;
  logic m_intr = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] be);
    logic [31:0] v;
    case (a[7:2])
      6'd0: v = ID;
      6'd1: v = m_ctrl;
      6'd2: v = stat_in;
      6'd3: v = 32'(m_status);
      6'd4: v = m_mask;
      6'd5: v = m_cnt;
      6'd6: v = m_scratch;
      default: v = 32'h0;
    endcase
    return v & bytes_of(be);
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
`ifdef TGT_REGS_DECERR_EN
    return (a[7:2] > 6'd6) ? 2'b11 : 2'b00;
`else
    return (a[7:2] == 6'd0) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
`ifdef TGT_REGS_DECERR_EN
    if (a[7:2] > 6'd6) return 2'b11;
    if (a[7:2] == 6'd0 || a[7:2] == 6'd2) return 2'b10;
    return 2'b00;
`else
    return (a[7:2] == 6'd0) ? 2'b00 : 2'b00;
`endif
  endfunction

  always @(posedge CLK) begin
    logic [NE-1:0] clr;
    logic cclr, nintr;
    logic [31:0] m;
    longint s;
    if (RST) begin
      m_ctrl = '0; m_mask = '0; m_scratch = '0; m_cnt = '0; m_status = '0; m_intr = 1'b0;
      exp_q.delete();
    end else begin
      nintr = |(m_status & m_mask[NE-1:0]);
      clr = '0;
      cclr = 1'b0;
      if (arvalid && arready) exp_q.push_back(model_read(araddr, aruser));
      if (awvalid && awready && wvalid && wready) begin
        m = bytes_of(wstrb);
        case (awaddr[7:2])
          6'd1: m_ctrl = (m_ctrl & ~m) | (wdata & m);
          6'd3: clr = NE'(wdata & m);
          6'd4: m_mask = (m_mask & ~m) | (wdata & m);
          6'd5: cclr = 1'b1;
          6'd6: m_scratch = (m_scratch & ~m) | (wdata & m);
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | event_in;
      s = longint'(m_cnt) + longint'($countones(event_in));
      m_cnt = cclr ? 32'h0 : ((s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0]);
      m_intr = nintr;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("intr_request", 32'(intr_request), 32'(m_intr));
      chk("ctrl_out", ctrl_out, m_ctrl);
    end
  end

  task automatic step();
    @(negedge CLK);
    if (ev_rand) begin
      event_in = NE'($urandom & $urandom & $urandom);
      stat_in = $urandom;
    end else begin
      event_in = ev_next;
      ev_next = '0;
    end
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int unsigned lead, input logic [NE-1:0] ev);
    bit ok;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s;
    for (int unsigned i = 0; i < lead; i++) begin
      step();
      chk("awready_without_w", 32'(awready), 32'h0);
    end
    wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (awready) ok = 1'b1;
    end
    chk("aw_handshake_timeout", 32'(ok), 32'h1);
    chk("wready_with_awready", 32'(wready), 32'h1);
    if (ev != '0) event_in = ev;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("awready_single_pulse", 32'(awready), 32'h0);
  endtask

  task automatic wr_resp(input int unsigned bdelay, input logic [1:0] er);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bvalid) ok = 1'b1; else step();
    end
    chk("bvalid_timeout", 32'(ok), 32'h1);
    chk("bresp", 32'(bresp), 32'(er));
    for (int unsigned i = 0; i < bdelay; i++) begin
      step();
      chk("bvalid_hold", 32'(bvalid), 32'h1);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_req(a, d, s, 0, '0);
    wr_resp(0, exp_wresp(a));
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] be, input int unsigned hold,
                    output logic [31:0] got);
    bit ok;
    int lat;
    logic [31:0] e;
    araddr = a; aruser = be; arvalid = 1'b1;
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      lat++;
      if (rvalid) ok = 1'b1;
    end
    arvalid = 1'b0;
    chk("rvalid_timeout", 32'(ok), 32'h1);
    chk("read_latency", 32'(lat), 32'd2);
    if (exp_q.size() == 0) begin
      chk("read_no_expectation", 32'h1, 32'h0);
      e = 32'h0;
    end else e = exp_q.pop_front();
    got = rdata;
    chk("rdata", rdata, e);
    chk("rresp", 32'(rresp), 32'(exp_rresp(a)));
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      chk("rvalid_hold", 32'(rvalid), 32'h1);
      chk("rdata_hold", rdata, e);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, d;
    RST = 1'b1;
    repeat (3) step();
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_intr", 32'(intr_request), 32'h0);
    RST = 1'b0;
    chk_en = 1'b1;
    step();

    rd(32'h00, 4'hF, 0, got);
    chk("id_value", got, 32'h6120_0001);

    wr(32'h04, 32'hA5A5_5A5A, 4'b0101);
    chk("ctrl_strobed", ctrl_out, 32'h00A5_005A);
    rd(32'h04, 4'b0011, 0, got);
    chk("ctrl_byte_enable", got, 32'h0000_005A);

    wr_req(32'h18, 32'hDEAD_BEEF, 4'hF, 5, '0);
    wr_resp(0, 2'b00);
    rd(32'h18, 4'hF, 0, got);
    chk("scratch_rw", got, 32'hDEAD_BEEF);

    wr(32'h10, 32'h0000_0008, 4'hF);
    ev_next = 8'h08;
    repeat (3) step();
    chk("intr_set", 32'(intr_request), 32'h1);
    rd(32'h0C, 4'hF, 0, got);
    chk("int_status_set", got, 32'h0000_0008);
    wr_req(32'h0C, 32'h0000_0008, 4'hF, 0, 8'h08);
    wr_resp(0, 2'b00);
    rd(32'h0C, 4'hF, 0, got);
    chk("set_beats_clear", got, 32'h0000_0008);
    wr(32'h0C, 32'h0000_0008, 4'hF);
    rd(32'h0C, 4'hF, 0, got);
    chk("w1c_clear", got, 32'h0);
    step();
    chk("intr_clear", 32'(intr_request), 32'h0);

    rd(32'h14, 4'hF, 0, got);
    chk("evt_cnt", got, 32'd2);
    wr(32'h14, 32'h0, 4'h0);
    rd(32'h14, 4'hF, 0, got);
    chk("evt_cnt_clear", got, 32'h0);

    rd(32'h18, 4'hF, 10, got);

    wr_req(32'h04, 32'h1111_1111, 4'hF, 0, '0);
    awaddr = 32'h18; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (6) begin
      step();
      chk("no_accept_while_b", 32'(awready), 32'h0);
      chk("bvalid_stall", 32'(bvalid), 32'h1);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    wr_req(32'h18, 32'h2222_2222, 4'hF, 0, '0);
    wr_resp(2, 2'b00);
    rd(32'h04, 4'hF, 0, got);
    chk("ctrl_after_stall", got, 32'h1111_1111);

    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    rd(32'h00, 4'hF, 0, got);
    chk("id_ro", got, ID);
    wr(32'h3C, 32'h1234_5678, 4'hF);
    rd(32'h3C, 4'hF, 0, got);
    chk("unmapped_zero", got, 32'h0);
    rd(32'hFFFF_FF04, 4'hF, 0, got);
    chk("upper_addr_ignored", got, 32'h1111_1111);

    ev_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 15) << 2) | ($urandom & 32'hFFFF_FF00);
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        wr_req(a, d, 4'($urandom), $urandom_range(0, 2), '0);
        wr_resp($urandom_range(0, 2), exp_wresp(a));
      end else begin
        rd(a, 4'($urandom), $urandom_range(0, 3), got);
      end
    end
    ev_rand = 1'b0;
    step();

    wr(32'h04, 32'hCAFE_F00D, 4'hF);
    araddr = 32'h04; aruser = 4'hF; arvalid = 1'b1;
    step();
    step();
    RST = 1'b1;
    arvalid = 1'b0;
    step();
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_arready", 32'(arready), 32'h0);
    chk("midrst_ctrl", ctrl_out, 32'h0);
    RST = 1'b0;
    step();
    rd(32'h04, 4'hF, 0, got);
    chk("ctrl_after_reset", got, 32'h0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
